ball_motion_ctrl: RTL and testbench
===================================

# ball_motion_ctrl

Ball-motion controller for the Pong datapath; the direct consumer of the frame-rate timer's terminal-count pulse. Each timer tick (`Tick`) moves the ball one step. The block also handles:
- bounces off the top and bottom walls and off both paddles;
- detection of a point, reported as a one-cycle score pulse;
- the serve/rally/score sequence, as a small state machine.

Outputs feed the renderer and the score counters.

## Interface
Parameters:
- `FIELD_W`, 160: playfield width in pixels.
- `FIELD_H`, 120: playfield height in pixels.
- `BALL_SIZE`, 4: ball edge length in pixels.
- `PADDLE_H`, 24: paddle height in pixels.
- `PAD_L_FACE`, 12: first column to the right of the left paddle.
- `PAD_R_FACE`, 148: first column of the right paddle.
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Tick`  in  1  one-cycle step strobe (timer terminal count).
- `Start`  in  1  serve request.
- `PaddleLY`  in  `Y_W`  top row of the left paddle.
- `PaddleRY`  in  `Y_W`  top row of the right paddle.
- `BallX`  out  `X_W`  ball left column.
- `BallY`  out  `Y_W`  ball top row.
- `Moving`  out  1  high while in `MOVE`.
- `Bounce`  out  1  one-cycle pulse on any wall or paddle reflection.
- `ScoreL`  out  1  one-cycle pulse: left player scored (ball exited right).
- `ScoreR`  out  1  one-cycle pulse: right player scored (ball exited left).

## Operation
States:
- `IDLE`: ball held at centre, CX = (`FIELD_W` − `BALL_SIZE`)/2 = 78, CY = (`FIELD_H` − `BALL_SIZE`)/2 = 58. `Tick` is ignored. `Start` → `MOVE`.
- `MOVE`: on each `Tick`, step by S with signed direction dx, dy (±1). `Start` is ignored.
- `SCORED`: lasts one cycle, during which the ball recentres. Then → `IDLE`.

Movement on each `Tick` in `MOVE` (S = step, default 1). All conditions use current x, y. y and x rules are evaluated in the same cycle.
- y, top wall: if dy = −1 and y < S → y = 0, dy = +1, `Bounce`.
- y, bottom wall: if dy = +1 and y + S > `FIELD_H` − `BALL_SIZE` → y = 116, dy = −1, `Bounce`.
- y, otherwise: y += dy·S.
- x, right side (dx = +1), first match wins:
  - If x + `BALL_SIZE` ≤ `PAD_R_FACE` < x + `BALL_SIZE` + S, and rows [y, y+3] overlap [`PaddleRY`, `PaddleRY`+23]: x = 144, dx = −1, `Bounce`.
  - Else if x + `BALL_SIZE` + S > `FIELD_W`: pulse `ScoreL`, → `SCORED`.
  - Else x += S.
- x, left side (dx = −1): mirror of the right side.
  - Hit condition: `PAD_L_FACE` ≤ x < `PAD_L_FACE` + S, with overlap against `PaddleLY`. Result: x = 12, dx = +1, `Bounce`.
  - Score condition: x < S → pulse `ScoreR`.
- A wall and a paddle reflection on the same tick produce a single `Bounce` pulse.
- On a score tick the y update is discarded.
- Serve direction:
  - After reset: dx = +1, dy = +1.
  - After a score: dx points toward the side that conceded. dy is kept.
- Arithmetic is unsigned. Compare in `X_W`+1 / `Y_W`+1 bits so that no comparison wraps.

## Timing
- Reset values: state `IDLE`, `BallX` = 78, `BallY` = 58, dx = dy = +1, S = 1, `Moving` = 0, `Bounce`/`ScoreL`/`ScoreR` = 0.
- All outputs are registered. The position update and any pulse appear on the edge that samples `Tick` high, giving one-cycle latency.
- `Start` and `Tick` high in the same `IDLE` cycle: enter `MOVE`, and the tick does not move the ball.
- `SCORED` → `IDLE` after exactly one cycle. `Moving` is 0 in both states.
- `Rst` asserted mid-rally: immediately return to reset values, independent of `Clk`.

## Configuration
- `BALL_SPEEDUP_EN` defined:
  - A 2-bit hit counter increments on each paddle bounce.
  - Each time it wraps (every 4th hit), S increases by 1, saturating at 3.
  - S and the counter return to 1 and 0 when entering `SCORED`.
- `BALL_SPEEDUP_EN` undefined: S is fixed at 1 and there is no counter logic.

## Test plan
- Reset, then 5 `Tick`s with no `Start` → `BallX` = 78, `BallY` = 58, `Moving` = 0, no pulses.
- Pulse `Start`, then 1 `Tick` → 79/59, `Moving` = 1.
- Continue to tick 58 (78+58/116), then tick 59 → `BallY` = 116, `BallX` = 137, one `Bounce`; tick 60 → `BallY` = 115.
- `PaddleRY` = 100: tick 66 → 144/109; tick 67 → `BallX` = 144, `BallY` = 108, `Bounce`, dx = −1.
- Same run with `PaddleRY` = 0: tick 67 → `BallX` = 145; tick 79 → `ScoreL` pulse; next cycle 78/58 in `IDLE`; the next serve moves right.
- With `BALL_SPEEDUP_EN`, bench tracks `PaddleLY`/`PaddleRY` to `BallY`: after the 4th paddle hit `BallX` changes by 2 per `Tick`; after a forced miss the step returns to 1.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: Pong ball stepper with wall/paddle reflection, point detection and serve/rally/score FSM.
// Latency: one cycle; position and pulses update on the edge that samples Tick high.
// Backpressure: none; Tick is a free-running strobe, consumed in MOVE and ignored elsewhere.
// Ports: Clk, Rst (async active-low), Tick/Start controls and PaddleLY/PaddleRY paddle top rows in;
//        BallX/BallY position, Moving level, Bounce/ScoreL/ScoreR one-cycle pulses out (all registered).
// Optional: define BALL_SPEEDUP_EN to raise the step by one after every 4th paddle hit (max 3).
module ball_motion_ctrl #(
    parameter int FIELD_W    = 160,
    parameter int FIELD_H    = 120,
    parameter int BALL_SIZE  = 4,
    parameter int PADDLE_H   = 24,
    parameter int PAD_L_FACE = 12,
    parameter int PAD_R_FACE = 148,
    parameter int X_W        = 8,
    parameter int Y_W        = 7
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Tick,
    input  logic           Start,
    input  logic [Y_W-1:0] PaddleLY,
    input  logic [Y_W-1:0] PaddleRY,
    output logic [X_W-1:0] BallX,
    output logic [Y_W-1:0] BallY,
    output logic           Moving,
    output logic           Bounce,
    output logic           ScoreL,
    output logic           ScoreR
);

    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, SCORED = 2'd2} state_t;

    localparam logic [X_W-1:0] CX      = X_W'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [Y_W-1:0] CY      = Y_W'((FIELD_H - BALL_SIZE) / 2);
    localparam logic [X_W-1:0] X_HIT_R = X_W'(PAD_R_FACE - BALL_SIZE);
    localparam logic [X_W-1:0] X_HIT_L = X_W'(PAD_L_FACE);
    localparam logic [Y_W-1:0] Y_BOT   = Y_W'(FIELD_H - BALL_SIZE);

    // One extra bit on every compare operand so sums near the field edge never wrap.
    localparam logic [X_W:0] XW_FIELD = (X_W+1)'(FIELD_W);
    localparam logic [X_W:0] XW_PAD_R = (X_W+1)'(PAD_R_FACE);
    localparam logic [X_W:0] XW_PAD_L = (X_W+1)'(PAD_L_FACE);
    localparam logic [X_W:0] XW_BALL  = (X_W+1)'(BALL_SIZE);
    localparam logic [Y_W:0] YW_BOT   = (Y_W+1)'(FIELD_H - BALL_SIZE);
    localparam logic [Y_W:0] YW_BALL1 = (Y_W+1)'(BALL_SIZE - 1);
    localparam logic [Y_W:0] YW_PAD1  = (Y_W+1)'(PADDLE_H - 1);

    state_t         state, state_nxt;
    logic [X_W-1:0] ball_x, x_nxt;
    logic [Y_W-1:0] ball_y, y_nxt, y_mv;
    logic           dx_neg, dx_neg_nxt;
    logic           dy_neg, dy_neg_nxt, dy_mv;
    logic           bounce_q, score_l_q, score_r_q, moving_q;
    logic           bounce_nxt, score_l_nxt, score_r_nxt;
    logic           wall_hit, paddle_hit;
    logic [1:0]     step;

    logic [X_W:0]   xe, stp_x, x_fwd;
    logic [Y_W:0]   ye, stp_y, y_fwd, pl, pr;
    logic           overlap_l, overlap_r;

    assign xe    = {1'b0, ball_x};
    assign stp_x = (X_W+1)'(step);
    assign x_fwd = xe + stp_x;
    assign ye    = {1'b0, ball_y};
    assign stp_y = (Y_W+1)'(step);
    assign y_fwd = ye + stp_y;
    assign pl    = {1'b0, PaddleLY};
    assign pr    = {1'b0, PaddleRY};

    // Ball rows [y, y+BALL_SIZE-1] against paddle rows [p, p+PADDLE_H-1].
    assign overlap_l = (ye <= pl + YW_PAD1) && (pl <= ye + YW_BALL1);
    assign overlap_r = (ye <= pr + YW_PAD1) && (pr <= ye + YW_BALL1);

`ifdef BALL_SPEEDUP_EN
    logic [1:0] hit_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            step    <= 2'd1;
            hit_cnt <= 2'd0;
        end else if (state == MOVE && state_nxt == SCORED) begin
            step    <= 2'd1;
            hit_cnt <= 2'd0;
        end else if (paddle_hit) begin
            hit_cnt <= hit_cnt + 2'd1;
            // The counter wrapping marks every 4th hit.
            if (hit_cnt == 2'd3 && step != 2'd3)
                step <= step + 2'd1;
        end
    end
`else
    assign step = 2'd1;
`endif

    always_comb begin
        state_nxt   = state;
        x_nxt       = ball_x;
        y_nxt       = ball_y;
        dx_neg_nxt  = dx_neg;
        dy_neg_nxt  = dy_neg;
        y_mv        = ball_y;
        dy_mv       = dy_neg;
        wall_hit    = 1'b0;
        paddle_hit  = 1'b0;
        bounce_nxt  = 1'b0;
        score_l_nxt = 1'b0;
        score_r_nxt = 1'b0;

        // Candidate vertical move; only committed on a non-scoring tick.
        if (dy_neg && ye < stp_y) begin
            y_mv     = '0;
            dy_mv    = 1'b0;
            wall_hit = 1'b1;
        end else if (!dy_neg && y_fwd > YW_BOT) begin
            y_mv     = Y_BOT;
            dy_mv    = 1'b1;
            wall_hit = 1'b1;
        end else if (dy_neg) begin
            y_mv = ball_y - Y_W'(step);
        end else begin
            y_mv = y_fwd[Y_W-1:0];
        end

        case (state)
            IDLE: begin
                if (Start)
                    state_nxt = MOVE;
            end
            MOVE: begin
                if (Tick) begin
                    if (!dx_neg) begin
                        if (xe + XW_BALL <= XW_PAD_R && XW_PAD_R < x_fwd + XW_BALL && overlap_r) begin
                            x_nxt      = X_HIT_R;
                            dx_neg_nxt = 1'b1;
                            paddle_hit = 1'b1;
                        end else if (x_fwd + XW_BALL > XW_FIELD) begin
                            score_l_nxt = 1'b1;
                        end else begin
                            x_nxt = x_fwd[X_W-1:0];
                        end
                    end else begin
                        if (XW_PAD_L <= xe && xe < XW_PAD_L + stp_x && overlap_l) begin
                            x_nxt      = X_HIT_L;
                            dx_neg_nxt = 1'b0;
                            paddle_hit = 1'b1;
                        end else if (xe < stp_x) begin
                            score_r_nxt = 1'b1;
                        end else begin
                            x_nxt = ball_x - X_W'(step);
                        end
                    end
                    // dx already points at the conceding side, so it is left alone on a score.
                    if (score_l_nxt || score_r_nxt) begin
                        state_nxt = SCORED;
                    end else begin
                        y_nxt      = y_mv;
                        dy_neg_nxt = dy_mv;
                        bounce_nxt = wall_hit | paddle_hit;
                    end
                end
            end
            SCORED: begin
                x_nxt     = CX;
                y_nxt     = CY;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            ball_x    <= CX;
            ball_y    <= CY;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            moving_q  <= 1'b0;
            bounce_q  <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ball_x    <= x_nxt;
            ball_y    <= y_nxt;
            dx_neg    <= dx_neg_nxt;
            dy_neg    <= dy_neg_nxt;
            moving_q  <= (state_nxt == MOVE);
            bounce_q  <= bounce_nxt;
            score_l_q <= score_l_nxt;
            score_r_q <= score_r_nxt;
        end
    end

    assign BallX  = ball_x;
    assign BallY  = ball_y;
    assign Moving = moving_q;
    assign Bounce = bounce_q;
    assign ScoreL = score_l_q;
    assign ScoreR = score_r_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: directed vectors for ball_motion_ctrl with hand-computed positions.
// Latency: outputs sampled 1 time unit after the edge that consumed each Tick.
// Backpressure: none; the bench drives one Tick per cycle in rallies.
module tb_ball_motion_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Tick;
    logic       Start;
    logic [6:0] PaddleLY;
    logic [6:0] PaddleRY;
    logic [7:0] BallX;
    logic [6:0] BallY;
    logic       Moving;
    logic       Bounce;
    logic       ScoreL;
    logic       ScoreR;

    int n_vec  = 0;
    int n_err  = 0;
    int tick_no = 0;

    always #5 Clk = ~Clk;

    ball_motion_ctrl dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tick     (Tick),
        .Start    (Start),
        .PaddleLY (PaddleLY),
        .PaddleRY (PaddleRY),
        .BallX    (BallX),
        .BallY    (BallY),
        .Moving   (Moving),
        .Bounce   (Bounce),
        .ScoreL   (ScoreL),
        .ScoreR   (ScoreR)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y);
        chk({tag, "_x"}, int'(BallX), x);
        chk({tag, "_y"}, int'(BallY), y);
    endtask

    // One Tick cycle; returns 1 time unit after the consuming edge.
    task automatic tick1();
        Tick = 1'b1;
        @(posedge Clk);
        #1;
        Tick = 1'b0;
        tick_no++;
    endtask

    task automatic tick_to(input int n);
        while (tick_no < n)
            tick1();
    endtask

    task automatic idle_cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic serve();
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start   = 1'b0;
        tick_no = 0;
    endtask

`ifdef BALL_SPEEDUP_EN
    int hits;
    int x0;
    int d;
    bit dir_r;
    bit scored;
`endif

    initial begin
        Rst      = 1'b0;
        Tick     = 1'b0;
        Start    = 1'b0;
        PaddleLY = 7'd0;
        PaddleRY = 7'd100;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;

        // Reset state
        chk_pos("rst", 78, 58);
        chk("rst_mov", int'(Moving), 0);
        chk("rst_bnc", int'(Bounce), 0);
        chk("rst_scl", int'(ScoreL), 0);
        chk("rst_scr", int'(ScoreR), 0);

        // Ticks in IDLE are ignored
        repeat (5) tick1();
        chk_pos("idle", 78, 58);
        chk("idle_mov", int'(Moving), 0);
        chk("idle_bnc", int'(Bounce), 0);

        // Run A: right paddle at 100, left paddle at 0
        serve();
        chk("srv_mov", int'(Moving), 1);
        chk_pos("srv", 78, 58);
        tick_to(1);   chk_pos("a1", 79, 59);   chk("a1_mov", int'(Moving), 1);
        tick_to(58);  chk_pos("a58", 136, 116); chk("a58_bnc", int'(Bounce), 0);
        tick_to(59);  chk_pos("a59", 137, 116); chk("a59_bnc", int'(Bounce), 1);
        tick_to(60);  chk_pos("a60", 138, 115); chk("a60_bnc", int'(Bounce), 0);
        tick_to(66);  chk_pos("a66", 144, 109);
        tick_to(67);  chk_pos("a67", 144, 108); chk("a67_bnc", int'(Bounce), 1);
        tick_to(68);  chk_pos("a68", 143, 107); chk("a68_bnc", int'(Bounce), 0);
        tick_to(175); chk_pos("a175", 36, 0);
        tick_to(176); chk_pos("a176", 35, 0);   chk("a176_bnc", int'(Bounce), 1);
        tick_to(177); chk_pos("a177", 34, 1);
        tick_to(199); chk_pos("a199", 12, 23);
        // Bottom paddle row 23 just touches ball top row 23
        tick_to(200); chk_pos("a200", 12, 24);  chk("a200_bnc", int'(Bounce), 1);
        tick_to(201); chk_pos("a201", 13, 25);

        // Asynchronous reset mid-rally, checked before the next edge
        @(posedge Clk);
        #3;
        Rst = 1'b0;
        #1;
        chk_pos("arst", 78, 58);
        chk("arst_mov", int'(Moving), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        // Run B: right paddle out of reach -> left player scores
        PaddleRY = 7'd0;
        PaddleLY = 7'd97;
        serve();
        tick_to(67); chk_pos("b67", 145, 108); chk("b67_bnc", int'(Bounce), 0);
        tick_to(78); chk_pos("b78", 156, 97);  chk("b78_scl", int'(ScoreL), 0);
        tick_to(79);
        chk("b79_scl", int'(ScoreL), 1);
        chk("b79_scr", int'(ScoreR), 0);
        chk("b79_mov", int'(Moving), 0);
        chk_pos("b79", 156, 97);
        idle_cyc();
        chk("bsc_scl", int'(ScoreL), 0);
        chk("bsc_mov", int'(Moving), 0);
        chk_pos("bsc", 78, 58);

        // Run C: serve goes right again, dy kept upward
        serve();
        tick_to(1);   chk_pos("c1", 79, 57);
        tick_to(59);  chk_pos("c59", 137, 0);   chk("c59_bnc", int'(Bounce), 1);
        tick_to(67);  chk_pos("c67", 144, 8);   chk("c67_bnc", int'(Bounce), 1);
        tick_to(176); chk_pos("c176", 35, 116); chk("c176_bnc", int'(Bounce), 1);
        tick_to(199); chk_pos("c199", 12, 93);
        // Left paddle top row 97 is one below the ball bottom row 96: miss
        tick_to(200); chk_pos("c200", 11, 92);  chk("c200_bnc", int'(Bounce), 0);
        tick_to(211); chk_pos("c211", 0, 81);   chk("c211_scr", int'(ScoreR), 0);
        tick_to(212);
        chk("c212_scr", int'(ScoreR), 1);
        chk("c212_scl", int'(ScoreL), 0);
        chk("c212_mov", int'(Moving), 0);
        chk_pos("c212", 0, 81);
        idle_cyc();
        chk("csc_scr", int'(ScoreR), 0);
        chk_pos("csc", 78, 58);

        // Start and Tick together in IDLE: enter MOVE without stepping
        Start = 1'b1;
        Tick  = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Tick  = 1'b0;
        chk("st_mov", int'(Moving), 1);
        chk_pos("st", 78, 58);
        tick_no = 0;
        tick1();
        chk_pos("st1", 77, 57);

`ifdef BALL_SPEEDUP_EN
        // Paddles follow the ball so every approach is a hit.
        hits  = 0;
        dir_r = 1'b0;
        for (int i = 0; i < 3000 && hits < 4; i++) begin
            PaddleLY = BallY;
            PaddleRY = BallY;
            tick1();
            if (Bounce && ((dir_r && BallX == 8'd144) || (!dir_r && BallX == 8'd12))) begin
                hits++;
                dir_r = ~dir_r;
            end
        end
        chk("spd_hits", hits, 4);
        x0 = int'(BallX);
        tick1();
        d = int'(BallX) - x0;
        if (d < 0) d = -d;
        chk("spd_step2", d, 2);

        // Keep paddles away from the ball until a point is scored.
        scored = 1'b0;
        for (int i = 0; i < 1000 && !scored; i++) begin
            PaddleLY = (BallY >= 7'd58) ? 7'd0 : 7'd93;
            PaddleRY = (BallY >= 7'd58) ? 7'd0 : 7'd93;
            tick1();
            if (ScoreL || ScoreR) scored = 1'b1;
        end
        chk("spd_miss", int'(scored), 1);
        idle_cyc();
        serve();
        tick1();
        d = int'(BallX) - 78;
        if (d < 0) d = -d;
        chk("spd_step1", d, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
